ex_mem_pipe: RTL and testbench

Parametrised EX/MEM pipeline stage with a valid/ready handshake, flush, and a saturating back-pressure counter. It sits between the execute stage and the memory stage. It carries the ALU result, branch outcome, decoded opcode/funct fields, destination register index and store data. Unlike a plain clocked register, it holds its contents under back-pressure, can be squashed by a flush, and can optionally decouple `in_ready_o` from `out_ready_i` with a skid entry.

---
 rtl/ex_mem_pipe.sv | 146 ++++++++++++++
 tb/tb_ex_mem_pipe.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_pipe.sv
// ex_mem_pipe: EX/MEM pipeline stage with a valid/ready handshake, flush and a
// saturating back-pressure counter.
// Optional skid entry: define EX_MEM_SKID_EN. With it, in_ready_o comes
// straight from a flop. Without it, in_ready_o is a single-register
// combinational ready.
// The NOP encodings match define.v: opcode_nop = addi (0010011),
// funct3_nop = 000, funct7_nop = 0000000.
module ex_mem_pipe #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned REGW = 5,
  parameter int unsigned CNTW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [XLEN-1:0] alu_out_i,
  input  logic            br_taken_i,
  input  logic [6:0]      opcode_i,
  input  logic [2:0]      funct3_i,
  input  logic [6:0]      funct7_i,
  input  logic [REGW-1:0] rd_i,
  input  logic [XLEN-1:0] rs2_data_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] alu_out_o,
  output logic            br_taken_o,
  output logic [6:0]      opcode_o,
  output logic [2:0]      funct3_o,
  output logic [6:0]      funct7_o,
  output logic [REGW-1:0] rd_o,
  output logic [XLEN-1:0] rs2_data_o,
  output logic [CNTW-1:0] stall_cnt_o
);

  localparam logic [6:0] OPCODE_NOP = 7'b0010011;
  localparam logic [2:0] FUNCT3_NOP = 3'b000;
  localparam logic [6:0] FUNCT7_NOP = 7'b0000000;

  typedef struct packed {
    logic [XLEN-1:0] alu;
    logic            br;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [REGW-1:0] rd;
    logic [XLEN-1:0] rs2;
  } pay_t;

  localparam pay_t NOP_PAY = '{alu: '0, br: 1'b0, opcode: OPCODE_NOP,
                               funct3: FUNCT3_NOP, funct7: FUNCT7_NOP,
                               rd: '0, rs2: '0};

  pay_t            in_pay;
  pay_t            main_q;
  logic            main_v;
  logic            in_fire;
  logic [CNTW-1:0] cnt_q;

  assign in_pay = '{alu: alu_out_i, br: br_taken_i, opcode: opcode_i,
                    funct3: funct3_i, funct7: funct7_i, rd: rd_i,
                    rs2: rs2_data_i};

  assign in_fire = in_valid_i && in_ready_o;

`ifdef EX_MEM_SKID_EN
  logic skid_v;
  pay_t skid_q;

  // Ready comes from the skid flag only, so there is no path from out_ready_i.
  assign in_ready_o = !skid_v;

  // Two-entry FIFO. Main is the head. Skid only fills while main is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_v <= 1'b0;
      main_q <= NOP_PAY;
      skid_v <= 1'b0;
      skid_q <= NOP_PAY;
    end else if (flush_i) begin
      main_v <= 1'b0;
      main_q <= NOP_PAY;
      skid_v <= 1'b0;
      skid_q <= NOP_PAY;
    end else if (!main_v || out_ready_i) begin
      // Main is empty or draining. Refill it from skid first, then from input.
      if (skid_v) begin
        main_v <= 1'b1;
        main_q <= skid_q;
        skid_v <= in_fire;
        skid_q <= in_fire ? in_pay : NOP_PAY;
      end else if (in_fire) begin
        main_v <= 1'b1;
        main_q <= in_pay;
      end else begin
        main_v <= 1'b0;
        main_q <= NOP_PAY;
      end
    end else if (in_fire) begin
      skid_v <= 1'b1;
      skid_q <= in_pay;
    end
  end
`else
  // Single register. Ready is combinational from out_ready_i.
  assign in_ready_o = !main_v || out_ready_i;

  // Load on transfer in, empty to NOP on a transfer out with nothing behind it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_v <= 1'b0;
      main_q <= NOP_PAY;
    end else if (flush_i) begin
      main_v <= 1'b0;
      main_q <= NOP_PAY;
    end else if (in_fire) begin
      main_v <= 1'b1;
      main_q <= in_pay;
    end else if (main_v && out_ready_i) begin
      main_v <= 1'b0;
      main_q <= NOP_PAY;
    end
  end
`endif

  // Saturating count of stalled cycles. Only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (main_v && !out_ready_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign out_valid_o = main_v;
  assign alu_out_o   = main_q.alu;
  assign br_taken_o  = main_q.br;
  assign opcode_o    = main_q.opcode;
  assign funct3_o    = main_q.funct3;
  assign funct7_o    = main_q.funct7;
  assign rd_o        = main_q.rd;
  assign rs2_data_o  = main_q.rs2;
  assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Testbench for ex_mem_pipe. It runs directed steps, then a random phase.
// Every step is checked against a FIFO reference model.
// With EX_MEM_SKID_EN the model holds two entries and ready is "not full".
// Without it, the model holds one entry.
module tb_ex_mem_pipe;

  localparam int unsigned CNTW = 4;
  localparam int unsigned CMAX = 15;

  typedef struct packed {
    logic [31:0] alu;
    logic        br;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [31:0] rs2;
  } ent_t;

  localparam ent_t NOP_E = '{alu: 32'h0, br: 1'b0, op: 7'h13, f3: 3'h0,
                             f7: 7'h00, rd: 5'h0, rs2: 32'h0};

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush_i = 1'b0;
  logic            in_valid_i = 1'b0;
  logic            in_ready_o;
  logic [31:0]     alu_out_i = '0;
  logic            br_taken_i = 1'b0;
  logic [6:0]      opcode_i = '0;
  logic [2:0]      funct3_i = '0;
  logic [6:0]      funct7_i = '0;
  logic [4:0]      rd_i = '0;
  logic [31:0]     rs2_data_i = '0;
  logic            out_valid_o;
  logic            out_ready_i = 1'b0;
  logic [31:0]     alu_out_o;
  logic            br_taken_o;
  logic [6:0]      opcode_o;
  logic [2:0]      funct3_o;
  logic [6:0]      funct7_o;
  logic [4:0]      rd_o;
  logic [31:0]     rs2_data_o;
  logic [CNTW-1:0] stall_cnt_o;

  int   total = 0;
  int   bad = 0;
  ent_t q[$];
  int   cnt = 0;

  ex_mem_pipe #(.XLEN(32), .REGW(5), .CNTW(CNTW)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .alu_out_i(alu_out_i), .br_taken_i(br_taken_i), .opcode_i(opcode_i),
    .funct3_i(funct3_i), .funct7_i(funct7_i), .rd_i(rd_i),
    .rs2_data_i(rs2_data_i), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .alu_out_o(alu_out_o),
    .br_taken_o(br_taken_o), .opcode_o(opcode_o), .funct3_o(funct3_o),
    .funct7_o(funct7_o), .rd_o(rd_o), .rs2_data_o(rs2_data_o),
    .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic ent_t dut_ent();
    return '{alu: alu_out_o, br: br_taken_o, op: opcode_o, f3: funct3_o,
             f7: funct7_o, rd: rd_o, rs2: rs2_data_o};
  endfunction

  function automatic logic model_ready();
`ifdef EX_MEM_SKID_EN
    return q.size() < 2;
`else
    return (q.size() == 0) || out_ready_i;
`endif
  endfunction

  task automatic drive(input logic v, input ent_t e);
    in_valid_i = v;
    alu_out_i = e.alu; br_taken_i = e.br; opcode_i = e.op; funct3_i = e.f3;
    funct7_i = e.f7; rd_i = e.rd; rs2_data_i = e.rs2;
  endtask

  function automatic ent_t rand_ent();
    ent_t e;
    e.alu = $urandom; e.br = 1'($urandom); e.op = 7'($urandom);
    e.f3 = 3'($urandom); e.f7 = 7'($urandom); e.rd = 5'($urandom);
    e.rs2 = $urandom;
    return e;
  endfunction

  task automatic check_all();
    chk("out_valid", 96'(out_valid_o), 96'(q.size() > 0));
    chk("payload", 96'(dut_ent()), 96'((q.size() > 0) ? q[0] : NOP_E));
    chk("in_ready", 96'(in_ready_o), 96'(model_ready()));
    chk("stall_cnt", 96'(stall_cnt_o), 96'(cnt));
  endtask

  task automatic model_edge();
    logic rdy;
    ent_t e;
    rdy = model_ready();
    e = '{alu: alu_out_i, br: br_taken_i, op: opcode_i, f3: funct3_i,
          f7: funct7_i, rd: rd_i, rs2: rs2_data_i};
    if (q.size() > 0 && !out_ready_i && cnt < CMAX) cnt++;
    if (flush_i) q.delete();
    else begin
      if (q.size() > 0 && out_ready_i) void'(q.pop_front());
      if (in_valid_i && rdy) q.push_back(e);
    end
  endtask

  // Check outputs at the falling edge, then advance the model at the rising
  // edge. Control returns 1 time unit after the rising edge.
  task automatic tick();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    flush_i = 1'b0; out_ready_i = 1'b0; drive(1'b0, NOP_E);
    q.delete(); cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    ent_t e;
    int c0;
    int seen;
    do_reset();

    // Reset, then idle
    out_ready_i = 1'b1;
    tick();
    chk("rst_in_ready", 96'(in_ready_o), 96'(1'b1));

    // Single transfer
    e = '{alu: 32'h0000_1004, br: 1'b1, op: 7'h03, f3: 3'h2, f7: 7'h00,
          rd: 5'd5, rs2: 32'hDEAD_BEEF};
    drive(1'b1, e);
    tick();
    drive(1'b0, NOP_E);
    chk("single_alu", 96'(alu_out_o), 96'(32'h0000_1004));
    chk("single_rd", 96'(rd_o), 96'(5'd5));
    chk("single_rs2", 96'(rs2_data_o), 96'(32'hDEAD_BEEF));
    chk("single_valid", 96'(out_valid_o), 96'(1'b1));
    tick();
    chk("single_empty", 96'(out_valid_o), 96'(1'b0));
    tick();

    // Back-pressure: load A, hold for 3 cycles while offering B, then release
    do_reset();
    out_ready_i = 1'b1;
    drive(1'b1, rand_ent());
    tick();
    out_ready_i = 1'b0;
    c0 = int'(stall_cnt_o);
    drive(1'b1, rand_ent());
    for (int i = 0; i < 3; i++) begin
      tick();
      if (!in_ready_o) drive(1'b0, NOP_E);
    end
    chk("bp_cnt_delta", 96'(stall_cnt_o), 96'(c0 + 3));
    drive(1'b0, NOP_E);
    out_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) tick();

    // Streaming: rd 1..8, with no bubbles allowed
    for (int k = 1; k <= 9; k++) begin
      if (k <= 8) begin
        e = rand_ent(); e.rd = 5'(k);
        drive(1'b1, e);
      end else drive(1'b0, NOP_E);
      if (k >= 2) begin
        chk("stream_valid", 96'(out_valid_o), 96'(1'b1));
        chk("stream_rd", 96'(rd_o), 96'(k - 1));
      end
      tick();
    end
    tick();

    // Flush a full stage while an input is presented
    out_ready_i = 1'b0;
    drive(1'b1, rand_ent());
    tick();
`ifdef EX_MEM_SKID_EN
    drive(1'b1, rand_ent());
    tick();
`endif
    c0 = int'(stall_cnt_o);
    flush_i = 1'b1;
    out_ready_i = 1'b1;
    drive(1'b1, rand_ent());
    tick();
    flush_i = 1'b0;
    drive(1'b0, NOP_E);
    chk("flush_valid", 96'(out_valid_o), 96'(1'b0));
    chk("flush_nop", 96'(dut_ent()), 96'(NOP_E));
    chk("flush_cnt", 96'(stall_cnt_o), 96'(c0));
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      if (out_valid_o) seen++;
      tick();
    end
    chk("flush_no_ghost", 96'(seen), 96'(0));

    // Counter saturation
    do_reset();
    out_ready_i = 1'b1;
    drive(1'b1, rand_ent());
    tick();
    drive(1'b0, NOP_E);
    out_ready_i = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk("sat_cnt", 96'(stall_cnt_o), 96'(CMAX));

    // Asynchronous reset in the middle of a clock period
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 96'(out_valid_o), 96'(1'b0));
    chk("arst_nop", 96'(dut_ent()), 96'(NOP_E));
    chk("arst_cnt", 96'(stall_cnt_o), 96'(0));
    chk("arst_ready", 96'(in_ready_o), 96'(1'b1));
    q.delete(); cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Random traffic with occasional flushes
    for (int i = 0; i < 400; i++) begin
      out_ready_i = ($urandom_range(0, 3) != 0);
      flush_i = ($urandom_range(0, 19) == 0);
      drive(1'($urandom), rand_ent());
      tick();
    end
    flush_i = 1'b0;
    drive(1'b0, NOP_E);
    out_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
